// File: rtl/tcdm_rr_mux_pkg.sv
// Shared types for the round-robin TCDM multiplexer.
// Default request/response structs mirror the TCDM typedef macros.
package tcdm_rr_mux_pkg;

  localparam int unsigned IdxMaxW = 8;

  typedef struct packed {
    logic               valid;
    logic [IdxMaxW-1:0] idx;
  } pipe_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  user;
  } dflt_q_t;

  typedef struct packed {
    dflt_q_t q;
    logic    q_valid;
  } dflt_req_t;

  typedef struct packed {
    logic [31:0] data;
  } dflt_p_t;

  typedef struct packed {
    dflt_p_t p;
    logic    p_valid;
    logic    q_ready;
  } dflt_rsp_t;

endpackage

// File: rtl/tcdm_rr_mux_if.sv
// One TCDM port: request from master, response from slave.
// Type parameters match the structs carried on the mux ports.
interface tcdm_rr_mux_if #(
  parameter type req_t = tcdm_rr_mux_pkg::dflt_req_t,
  parameter type rsp_t = tcdm_rr_mux_pkg::dflt_rsp_t
);

  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/tcdm_rr_arb_pick.sv
// Round-robin first-one finder: first valid port at or after rr_i.
// Falls back to rr_i when nothing is valid.
module tcdm_rr_arb_pick #(
  parameter int unsigned NrPorts = 2,
  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0] valid_i,
  input  logic [IdxW-1:0]    rr_i,
  output logic [IdxW-1:0]    grant_o,
  output logic               any_o
);

  localparam int Np = NrPorts;

  logic [IdxW-1:0] j;

  // Scan downwards so the closest port to rr_i wins last.
  always_comb begin
    grant_o = rr_i;
    any_o   = 1'b0;
    j       = '0;
    for (int off = Np - 1; off >= 0; off--) begin
      j = IdxW'((int'(rr_i) + off) % Np);
      if (valid_i[j]) begin
        grant_o = j;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_rr_mux.sv
// Round-robin mux sharing one TCDM port among NrPorts masters,
// with fixed-latency response routing back to the accepted master.
module tcdm_rr_mux
  import tcdm_rr_mux_pkg::*;
#(
  parameter int unsigned NrPorts     = 2,
  parameter type         tcdm_req_t  = dflt_req_t,
  parameter type         tcdm_rsp_t  = dflt_rsp_t,
  parameter int unsigned RespLatency = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  tcdm_req_t in_req_i [NrPorts],
  output tcdm_rsp_t in_rsp_o [NrPorts],
  output tcdm_req_t out_req_o,
  input  tcdm_rsp_t out_rsp_i
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int Np  = NrPorts;
  localparam int Lat = RespLatency;

  typedef logic [IdxW-1:0] idx_t;

  logic [NrPorts-1:0] valid;
  idx_t        rr_q;
  idx_t        lock_idx_q;
  idx_t        pick;
  idx_t        grant;
  idx_t        rr_next;
  logic        lock_q;
  logic        any;
  logic        hs;
  pipe_entry_t pipe_q [Lat];
  pipe_entry_t tail;

  always_comb begin
    valid = '0;
    for (int i = 0; i < Np; i++) begin
      valid[i] = in_req_i[i].q_valid;
    end
  end

  tcdm_rr_arb_pick #(
    .NrPorts (NrPorts)
  ) i_pick (
    .valid_i (valid),
    .rr_i    (rr_q),
    .grant_o (pick),
    .any_o   (any)
  );

  assign grant   = lock_q ? lock_idx_q : pick;
  assign hs      = any & out_rsp_i.q_ready;
  assign rr_next = idx_t'((int'(grant) + 1) % Np);
  assign tail    = pipe_q[Lat-1];

  always_comb begin
    out_req_o         = in_req_i[grant];
    out_req_o.q_valid = any;
  end

  always_comb begin
    for (int i = 0; i < Np; i++) begin
      in_rsp_o[i]         = '0;
      in_rsp_o[i].p       = out_rsp_i.p;
      in_rsp_o[i].q_ready = out_rsp_i.q_ready
                          & valid[i]
                          & (grant == idx_t'(i));
      in_rsp_o[i].p_valid = out_rsp_i.p_valid
                          & tail.valid
                          & (tail.idx == IdxMaxW'(i));
    end
  end

  // A stalled grant is locked so the downstream request stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      rr_q   <= rr_next;
      lock_q <= 1'b0;
    end else if (lock_q && !valid[lock_idx_q]) begin
      lock_q <= 1'b0;
    end else if (any) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Lat; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0].valid <= hs;
      pipe_q[0].idx   <= IdxMaxW'(grant);
      for (int k = 1; k < Lat; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_expected : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    out_rsp_i.p_valid |-> tail.valid
  ) else $error("tcdm_rr_mux: unexpected downstream response");

  a_rsp_on_time : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    tail.valid |-> out_rsp_i.p_valid
  ) else $error("tcdm_rr_mux: downstream response missing");

  a_lock_held : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> valid[lock_idx_q]
  ) else $error("tcdm_rr_mux: locked requester dropped q_valid");
`endif

endmodule

// File: tb/tb_tcdm_rr_mux.sv
// Bench for tcdm_rr_mux: two instances (latency 1 and 2) fed alike,
// checked every cycle against a reference arbiter and response scoreboard.
module tb_tcdm_rr_mux;
  import tcdm_rr_mux_pkg::*;

  typedef struct {
    int          due;
    int          port;
    int          lat;
    logic [31:0] data;
  } sb_t;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      rdy;
  dflt_req_t in_req  [4];
  dflt_rsp_t in_rsp1 [4];
  dflt_rsp_t in_rsp2 [4];

  tcdm_rr_mux_if dn1 ();
  tcdm_rr_mux_if dn2 ();

  logic        s1_v;
  logic [31:0] s1_a;
  logic        s2_v [2];
  logic [31:0] s2_a [2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_rr = 0;
  int   m_lidx = 0;
  bit   m_lock = 1'b0;
  int   last_hs = -1;
  sb_t  sb [$];

  always #5 clk = ~clk;

  tcdm_rr_mux #(
    .NrPorts     (4),
    .tcdm_req_t  (dflt_req_t),
    .tcdm_rsp_t  (dflt_rsp_t),
    .RespLatency (1)
  ) dut1 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_req_i  (in_req),
    .in_rsp_o  (in_rsp1),
    .out_req_o (dn1.req),
    .out_rsp_i (dn1.rsp)
  );

  tcdm_rr_mux #(
    .NrPorts     (4),
    .tcdm_req_t  (dflt_req_t),
    .tcdm_rsp_t  (dflt_rsp_t),
    .RespLatency (2)
  ) dut2 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_req_i  (in_req),
    .in_rsp_o  (in_rsp2),
    .out_req_o (dn2.req),
    .out_rsp_i (dn2.rsp)
  );

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0F0F);
  endfunction

  // Fixed-latency slave models, cleared by reset like the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s2_v[0] <= 1'b0;
      s2_v[1] <= 1'b0;
      s2_a[0] <= '0;
      s2_a[1] <= '0;
    end else begin
      s1_v    <= dn1.req.q_valid & rdy;
      s1_a    <= dn1.req.q.addr;
      s2_v[0] <= dn2.req.q_valid & rdy;
      s2_a[0] <= dn2.req.q.addr;
      s2_v[1] <= s2_v[0];
      s2_a[1] <= s2_a[0];
    end
  end

  always_comb begin
    dn1.rsp         = '0;
    dn1.rsp.q_ready = rdy;
    dn1.rsp.p_valid = s1_v;
    dn1.rsp.p.data  = s1_v ? rdata(s1_a) : 32'h0;
    dn2.rsp         = '0;
    dn2.rsp.q_ready = rdy;
    dn2.rsp.p_valid = s2_v[1];
    dn2.rsp.p.data  = s2_v[1] ? rdata(s2_a[1]) : 32'h0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] v);
    if (m_lock) return m_lidx;
    for (int off = 0; off < 4; off++) begin
      if (v[(m_rr + off) % 4]) return (m_rr + off) % 4;
    end
    return m_rr;
  endfunction

  task automatic check_cycle();
    logic [3:0]  v;
    int          g;
    logic        any_v;
    logic        exp_pv [2][4];
    logic [31:0] exp_d  [2][4];
    logic [31:0] ga;
    cyc++;
    if (!rst_n) begin
      m_rr    = 0;
      m_lock  = 1'b0;
      m_lidx  = 0;
      last_hs = -1;
      sb.delete();
    end
    for (int i = 0; i < 4; i++) v[i] = in_req[i].q_valid;
    any_v = |v;
    g     = ref_pick(v);
    ga    = in_req[g].q.addr;
    chk("out_valid_l1", 32'(dn1.req.q_valid), 32'(any_v));
    chk("out_valid_l2", 32'(dn2.req.q_valid), 32'(any_v));
    chk("out_addr_l1", dn1.req.q.addr, ga);
    chk("out_addr_l2", dn2.req.q.addr, ga);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q_ready_l1_p%0d", i), 32'(in_rsp1[i].q_ready),
          32'(rdy & v[i] & (g == i)));
      chk($sformatf("q_ready_l2_p%0d", i), 32'(in_rsp2[i].q_ready),
          32'(rdy & v[i] & (g == i)));
    end
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) begin
        exp_pv[l][i] = 1'b0;
        exp_d[l][i]  = '0;
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due <= cyc) begin
        exp_pv[sb[k].lat-1][sb[k].port] = 1'b1;
        exp_d[sb[k].lat-1][sb[k].port]  = sb[k].data;
        sb.delete(k);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("p_valid_l1_p%0d", i), 32'(in_rsp1[i].p_valid),
          32'(exp_pv[0][i]));
      chk($sformatf("p_valid_l2_p%0d", i), 32'(in_rsp2[i].p_valid),
          32'(exp_pv[1][i]));
      if (exp_pv[0][i])
        chk($sformatf("p_data_l1_p%0d", i), in_rsp1[i].p.data, exp_d[0][i]);
      if (exp_pv[1][i])
        chk($sformatf("p_data_l2_p%0d", i), in_rsp2[i].p.data, exp_d[1][i]);
    end
    if (rst_n) begin
      last_hs = -1;
      if (any_v && rdy) begin
        sb.push_back('{due: cyc + 1, port: g, lat: 1, data: rdata(ga)});
        sb.push_back('{due: cyc + 2, port: g, lat: 2, data: rdata(ga)});
        last_hs = g;
        m_rr    = (g + 1) % 4;
        m_lock  = 1'b0;
      end else if (m_lock && !v[m_lidx]) begin
        m_lock = 1'b0;
      end else if (any_v) begin
        m_lock = 1'b1;
        m_lidx = g;
      end
    end
  endtask

  always @(negedge clk) check_cycle();

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a);
    in_req[p]         = '0;
    in_req[p].q.addr  = a;
    in_req[p].q.data  = ~a;
    in_req[p].q.strb  = 4'hF;
    in_req[p].q_valid = 1'b1;
  endtask

  task automatic clr_req(input int p);
    in_req[p] = '0;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 4; i++) clr_req(i);
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr_all();
    step(3);
    rst_n = 1'b1;
    step(1);

    // all ports valid, slave always ready: grants rotate 0,1,2,3
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + 32'(i * 16));
    step(8);
    clr_all();
    step(2);

    // single read from port 2
    set_req(2, 32'h100);
    step(1);
    clr_req(2);
    step(3);

    // stalled port 1 keeps its grant while port 0 joins
    rdy = 1'b0;
    set_req(1, 32'h200);
    step(2);
    set_req(0, 32'h300);
    step(1);
    rdy = 1'b1;
    step(1);
    clr_req(1);
    step(1);
    clr_req(0);
    step(2);

    // consecutive handshakes to ports 3 then 0
    set_req(3, 32'h400);
    set_req(0, 32'h500);
    step(1);
    clr_req(3);
    step(1);
    clr_req(0);
    step(3);

    // reset with responses in flight
    set_req(2, 32'h600);
    step(1);
    clr_req(2);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    set_req(1, 32'h700);
    set_req(3, 32'h800);
    step(1);
    clr_req(1);
    step(1);
    clr_req(3);
    step(2);

    // random traffic; a port holds its request until accepted
    for (int c = 0; c < 400; c++) begin
      if (last_hs >= 0) clr_req(last_hs);
      for (int i = 0; i < 4; i++) begin
        if (!in_req[i].q_valid && $urandom_range(0, 2) != 0) begin
          set_req(i, $urandom() & 32'hFFFF_FFFC);
          in_req[i].q.write = 1'($urandom_range(0, 1));
          in_req[i].q.user  = 2'($urandom_range(0, 3));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    if (last_hs >= 0) clr_req(last_hs);
    clr_all();
    rdy = 1'b1;
    step(4);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
